// File: rtl/demux1to4_deser.sv
// demux1to4_deser: frame deserialiser and 1-to-3 channel steering.
// A frame opens with `start` (which also captures `sel`). WIDTH payload bits
// then arrive MSB first on din/din_valid, and the completed word is handed to
// channel sel over a valid/ready handshake. Select code 2'b11 is reserved:
// its frames are consumed and counted as drops.
// Optional build macro DEMUX_PARITY_EN: adds a trailing even-parity bit to
// each frame. A frame whose parity fails is dropped like a reserved one.
module demux1to4_deser #(
    parameter int WIDTH      = 4,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            sel,
    input  logic                  din,
    input  logic                  din_valid,
    output logic                  busy,
    output logic [WIDTH-1:0]      dout,
    output logic [2:0]            dout_valid,
    input  logic [2:0]            dout_ready,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SHIFT   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;

`ifdef DEMUX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int              CNT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic [1:0]            state_reg, state_next;
    logic [WIDTH-1:0]      sreg_reg, sreg_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [1:0]            sel_q_reg, sel_q_next;
    logic [WIDTH-1:0]      dout_reg, dout_next;
    logic [2:0]            dout_valid_reg, dout_valid_next;
    logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic                  err_reg, err_next;

    logic [2:0]            sel_hot;
    logic                  handshake;
    logic [WIDTH-1:0]      word_shifted;
    logic [WIDTH-1:0]      frame_word;
    logic                  frame_ok;

    // One-hot decode of the captured channel. Code 3 decodes to all zeros.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sel_hot
        assign sel_hot[gi] = (sel_q_reg == 2'(gi));
    end

    // Only the ready bit of the selected channel can complete a delivery.
    assign handshake    = |(dout_ready & sel_hot);
    assign word_shifted = {sreg_reg[WIDTH-2:0], din};

`ifdef DEMUX_PARITY_EN
    // The final bit is the parity bit. The payload is already in sreg.
    assign frame_word = sreg_reg;
    assign frame_ok   = ~(^{sreg_reg, din});
`else
    // The final bit is the last payload bit. It is merged in directly.
    assign frame_word = word_shifted;
    assign frame_ok   = 1'b1;
`endif

    // Next-state logic: frame capture, shifting, drop accounting, delivery.
    always_comb begin
        state_next      = state_reg;
        sreg_next       = sreg_reg;
        cnt_next        = cnt_reg;
        sel_q_next      = sel_q_reg;
        dout_next       = dout_reg;
        dout_valid_next = dout_valid_reg;
        drop_cnt_next   = drop_cnt_reg;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sel_q_next = sel;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (din_valid) begin
                    if (cnt_reg == LAST_BIT) begin
                        if ((sel_q_reg == 2'b11) || !frame_ok) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                            if (drop_cnt_reg != '1) begin
                                drop_cnt_next = drop_cnt_reg + 1'b1;
                            end
                        end else begin
                            dout_next       = frame_word;
                            dout_valid_next = sel_hot;
                            state_next      = DELIVER;
                        end
                    end else begin
                        sreg_next = word_shifted;
                        cnt_next  = cnt_reg + 1'b1;
                    end
                end
            end
            DELIVER: begin
                if (handshake) begin
                    dout_valid_next = 3'b000;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next      = IDLE;
                dout_valid_next = 3'b000;
            end
        endcase
    end

    // State registers. A reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sreg_reg       <= '0;
            cnt_reg        <= '0;
            sel_q_reg      <= 2'b00;
            dout_reg       <= '0;
            dout_valid_reg <= 3'b000;
            drop_cnt_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sreg_reg       <= sreg_next;
            cnt_reg        <= cnt_next;
            sel_q_reg      <= sel_q_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            drop_cnt_reg   <= drop_cnt_next;
            err_reg        <= err_next;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign drop_cnt   = drop_cnt_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_demux1to4_deser.sv
// Testbench for demux1to4_deser (WIDTH=4, DROP_CNT_W=8).
// Runs a table of directed frames, a drop-counter saturation run, reset
// mid-frame, and randomized frames. Expected outcomes come from the frame
// rules: a reserved select (or a bad parity bit) means a drop; any other
// frame delivers its payload on channel sel.
module tb_demux1to4_deser;

    localparam int W = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    sel;
    logic          din;
    logic          din_valid;
    logic          busy;
    logic [W-1:0]  dout;
    logic [2:0]    dout_valid;
    logic [2:0]    dout_ready;
    logic [DW-1:0] drop_cnt;
    logic          err;

    int checks = 0;
    int errors = 0;
    int model_drops = 0;

    typedef struct {
        logic [1:0]   vsel;
        logic [W-1:0] payload;
        int           gap;
        int           delay;
        logic         pflip;
        logic [W-1:0] exp_dout;
        logic [2:0]   exp_valid;
    } frame_vec_t;

    frame_vec_t vecs[6];

    demux1to4_deser #(.WIDTH(W), .DROP_CNT_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .sel        (sel),
        .din        (din),
        .din_valid  (din_valid),
        .busy       (busy),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .drop_cnt   (drop_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_drop_cnt();
        return (model_drops > 255) ? 32'd255 : 32'(model_drops);
    endfunction

    // Sends one frame and checks its outcome. Inputs are driven on the
    // falling edge. Outputs are sampled on the falling edge before new
    // inputs are driven.
    task automatic do_frame(input logic [1:0] fsel, input logic [W-1:0] payload,
                            input int gap, input int delay, input logic pflip,
                            input logic [W-1:0] exp_dout, input logic [2:0] exp_valid);
        logic [2:0] own;
        own = 3'(3'b001 << fsel);
        @(negedge clk);
        start      = 1'b1;
        sel        = fsel;
        dout_ready = (delay == 0) ? own : 3'b000;
        @(negedge clk);
        start = 1'b0;
        sel   = 2'($urandom_range(0, 3));
        check("busy_in_shift", 32'(busy), 32'd1);
        for (int i = W - 1; i >= 0; i--) begin
            repeat (gap) begin
                din_valid = 1'b0;
                din       = 1'($urandom_range(0, 1));
                start     = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            din_valid = 1'b1;
            din       = payload[i];
            @(negedge clk);
        end
`ifdef DEMUX_PARITY_EN
        repeat (gap) begin
            din_valid = 1'b0;
            @(negedge clk);
        end
        din_valid = 1'b1;
        din       = (^payload) ^ pflip;
        @(negedge clk);
`endif
        din_valid = 1'b0;
        if (exp_valid == 3'b000) begin
            model_drops++;
            check("drop_err_pulse", 32'(err), 32'd1);
            check("drop_no_valid", 32'(dout_valid), 32'd0);
            check("drop_cnt", 32'(drop_cnt), exp_drop_cnt());
            @(negedge clk);
            check("drop_err_low", 32'(err), 32'd0);
            check("drop_busy_low", 32'(busy), 32'd0);
            $display("frame sel=%0d data=%h dropped, drop_cnt=%0d", fsel, payload, drop_cnt);
        end else begin
            check("dlv_valid", 32'(dout_valid), 32'(exp_valid));
            check("dlv_dout", 32'(dout), 32'(exp_dout));
            check("dlv_err_low", 32'(err), 32'd0);
            for (int k = 0; k < delay; k++) begin
                dout_ready = ~own;
                @(negedge clk);
                check("hold_valid", 32'(dout_valid), 32'(exp_valid));
                check("hold_dout", 32'(dout), 32'(exp_dout));
            end
            // This is the handshake cycle. A start here must be ignored.
            dout_ready = own;
            start      = 1'b1;
            sel        = 2'b00;
            @(negedge clk);
            start      = 1'b0;
            dout_ready = 3'b000;
            check("hs_valid_clear", 32'(dout_valid), 32'd0);
            check("hs_busy_low", 32'(busy), 32'd0);
            check("hs_dout_kept", 32'(dout), 32'(exp_dout));
            $display("frame sel=%0d data=%h delivered after %0d wait cycles", fsel, payload, delay);
        end
    endtask

    initial begin
        logic [1:0]   rs;
        logic [W-1:0] rp;
        logic         rf;
        logic [2:0]   rv;

        vecs[0] = '{2'b01, 4'hB, 0, 0, 1'b0, 4'hB, 3'b010};
        vecs[1] = '{2'b10, 4'h6, 2, 6, 1'b0, 4'h6, 3'b100};
        vecs[2] = '{2'b00, 4'h9, 1, 2, 1'b0, 4'h9, 3'b001};
        vecs[3] = '{2'b11, 4'h5, 0, 0, 1'b0, 4'h0, 3'b000};
        vecs[4] = '{2'b00, 4'hF, 0, 1, 1'b0, 4'hF, 3'b001};
        vecs[5] = '{2'b10, 4'h0, 1, 0, 1'b0, 4'h0, 3'b100};

        rst_n      = 1'b0;
        start      = 1'b0;
        sel        = 2'b00;
        din        = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);

        foreach (vecs[i]) begin
            do_frame(vecs[i].vsel, vecs[i].payload, vecs[i].gap, vecs[i].delay,
                     vecs[i].pflip, vecs[i].exp_dout, vecs[i].exp_valid);
        end

        // Reserved-select frames until the drop counter saturates.
        for (int n = 0; n < 256; n++) begin
            do_frame(2'b11, 4'($urandom_range(0, 15)), 0, 0, 1'b0, 4'h0, 3'b000);
        end
        check("drop_cnt_saturated", 32'(drop_cnt), 32'd255);

        // Reset after the second payload bit discards the frame.
        @(negedge clk);
        start = 1'b1;
        sel   = 2'b00;
        @(negedge clk);
        start     = 1'b0;
        din_valid = 1'b1;
        din       = 1'b1;
        @(negedge clk);
        din = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n       = 1'b1;
        model_drops = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        @(negedge clk);
        check("midrst_idle_valid", 32'(dout_valid), 32'd0);
        do_frame(2'b00, 4'h3, 0, 0, 1'b0, 4'h3, 3'b001);

`ifdef DEMUX_PARITY_EN
        do_frame(2'b01, 4'hB, 0, 0, 1'b0, 4'hB, 3'b010);
        do_frame(2'b01, 4'hB, 0, 0, 1'b1, 4'h0, 3'b000);
`endif

        // Randomized frames checked against the frame rules.
        for (int n = 0; n < 200; n++) begin
            rs = 2'($urandom_range(0, 3));
            rp = 4'($urandom_range(0, 15));
`ifdef DEMUX_PARITY_EN
            rf = 1'($urandom_range(0, 1));
`else
            rf = 1'b0;
`endif
            rv = ((rs == 2'b11) || rf) ? 3'b000 : 3'(3'b001 << rs);
            do_frame(rs, rp, $urandom_range(0, 2), $urandom_range(0, 3), rf, rp, rv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
